// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the future transmitter.
// Latency: n/a (types, constants and helpers only); backpressure: n/a.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for one asynchronous input, with a selectable reset value.
// Latency: 2 cycles; backpressure: none.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: configurable width, parity, stop bits; flags framing, parity, break.
// Latency: sgn one cycle after the last stop sample; backpressure: none, consumer must keep up.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in,
    output logic                 sgn,
    output logic [DATA_BITS-1:0] data,
    output logic                 error,
    output logic                 parity_err,
    output logic                 brk,
    output logic                 busy
);
    import uart_pkg::*;

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = cnt_width(CLKS_PER_BIT);
    localparam int IW   = cnt_width(DATA_BITS + 1);

    logic                 rx_s;
    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr;
    logic                 stop_hi;
    logic                 half_tick, bit_tick, last_data, last_stop;
    logic                 frame_done;
    logic                 par_mis;
    logic                 par_hi;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (rx_s)
    );

    assign half_tick = (cnt == CW'(HALF - 1));
    assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));
    assign last_data = (idx == IW'(DATA_BITS - 1));
    assign last_stop = (idx == IW'(STOP_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:      if (!rx_s) state_nxt = ST_START;
            ST_START:     if (half_tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (bit_tick && last_data)
                              state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (bit_tick) state_nxt = ST_STOP;
            // A bad stop bit may mean a held-low break; wait for the line to recover.
            ST_STOP:      if (bit_tick && last_stop)
                              state_nxt = (ferr || !rx_s) ? ST_WAIT_HIGH : ST_IDLE;
            ST_WAIT_HIGH: if (rx_s) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_STOP) && bit_tick && last_stop;
    end

    always_comb begin
        par_mis = 1'b0;
        if (PARITY == PAR_EVEN)     par_mis = ^{shreg, par_bit};
        else if (PARITY == PAR_ODD) par_mis = ~^{shreg, par_bit};
    end

    assign par_hi = (PARITY != PAR_NONE) && par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            ferr    <= 1'b0;
            stop_hi <= 1'b0;
        end else begin
            if (state == ST_IDLE || state == ST_WAIT_HIGH || state_nxt != state || bit_tick)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (state_nxt != state)
                idx <= '0;
            else if (bit_tick && (state == ST_DATA || state == ST_STOP))
                idx <= idx + IW'(1);

            if (state == ST_IDLE) begin
                ferr    <= 1'b0;
                stop_hi <= 1'b0;
            end

            if (bit_tick) begin
                unique case (state)
                    ST_DATA:   shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                    ST_PARITY: par_bit <= rx_s;
                    ST_STOP: begin
                        ferr    <= ferr | ~rx_s;
                        stop_hi <= stop_hi | rx_s;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Result registers hold the last frame until the next sgn.
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn        <= 1'b0;
            data       <= '0;
            error      <= 1'b0;
            parity_err <= 1'b0;
            brk        <= 1'b0;
        end else begin
            sgn <= frame_done;
            if (frame_done) begin
                data       <= shreg;
                error      <= ferr | ~rx_s;
                parity_err <= par_mis;
                brk        <= ~|shreg & ~par_hi & ~stop_hi & ~rx_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1, 8E1 and 7O2 instances on separate serial lines.
// Frame vectors from a table, plus hand sequences for glitch, break, back-to-back and reset.
module tb_uart_rx;

    localparam int CPB = 16;

    typedef struct {
        int         sel;
        logic [8:0] word;
        logic       par;
        logic [1:0] stopv;
        logic [8:0] edata;
        logic       eerr;
        logic       eperr;
        logic       ebrk;
        int         lat;
    } vec_t;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [2:0] line = 3'b111;
    logic [2:0] sgn, error, perr, brk, busy;
    logic [7:0] data_n, data_e;
    logic [6:0] data_o;

    int         cyc  = 0;
    int         nvec = 0;
    int         nerr = 0;
    int         nsgn [3] = '{0, 0, 0};
    int         hcyc [3][8];
    logic [8:0] hdat [3][8];
    vec_t       vt [12];

    always #1 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
        .clk(clk), .rst(rst), .in(line[0]), .sgn(sgn[0]), .data(data_n),
        .error(error[0]), .parity_err(perr[0]), .brk(brk[0]), .busy(busy[0]));
    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e (
        .clk(clk), .rst(rst), .in(line[1]), .sgn(sgn[1]), .data(data_e),
        .error(error[1]), .parity_err(perr[1]), .brk(brk[1]), .busy(busy[1]));
    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_o (
        .clk(clk), .rst(rst), .in(line[2]), .sgn(sgn[2]), .data(data_o),
        .error(error[2]), .parity_err(perr[2]), .brk(brk[2]), .busy(busy[2]));

    function automatic logic [8:0] rd_data(input int sel);
        case (sel)
            0:       return {1'b0, data_n};
            1:       return {1'b0, data_e};
            default: return {2'b00, data_o};
        endcase
    endfunction

    function automatic int nbits(input int sel);
        return (sel == 2) ? 7 : 8;
    endfunction

    function automatic int nstop(input int sel);
        return (sel == 2) ? 2 : 1;
    endfunction

    // Strobe history, sampled away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (sgn[i] === 1'b1) begin
                hcyc[i][nsgn[i] % 8] = cyc;
                hdat[i][nsgn[i] % 8] = rd_data(i);
                nsgn[i] = nsgn[i] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Hold a line level for ncyc cycles; always returns 1 time unit after a rising edge.
    task automatic drive(input int sel, input logic b, input int ncyc);
        line[sel] = b;
        repeat (ncyc) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int sel, input logic [8:0] word, input logic par,
                              input logic [1:0] stopv);
        drive(sel, 1'b0, CPB);
        for (int k = 0; k < nbits(sel); k++) drive(sel, word[k], CPB);
        if (sel != 0) drive(sel, par, CPB);
        for (int j = 0; j < nstop(sel); j++) drive(sel, stopv[j], CPB);
        line[sel] = 1'b1;
    endtask

    task automatic check_idle_outputs(input int sel, input string tag);
        check({tag, ".sgn"},  sgn[sel],   0);
        check({tag, ".data"}, rd_data(sel), 0);
        check({tag, ".err"},  error[sel], 0);
        check({tag, ".perr"}, perr[sel],  0);
        check({tag, ".brk"},  brk[sel],   0);
        check({tag, ".busy"}, busy[sel],  0);
    endtask

    // Line falls right after edge S; sync gives t0 = S+3, so sgn is seen after edge
    // S + 3 + HALF + (bits after start)*CPB, i.e. the lat field.
    task automatic apply(input vec_t v, input string tag);
        int n0, s, n;
        @(posedge clk); #1;
        n0 = nsgn[v.sel];
        s  = cyc;
        send_frame(v.sel, v.word, v.par, v.stopv);
        repeat (20) @(posedge clk);
        #1;
        n = nsgn[v.sel] - n0;
        check({tag, ".sgn_count"}, n, 1);
        if (n > 0) check({tag, ".latency"}, hcyc[v.sel][(nsgn[v.sel] - 1) % 8] - s, v.lat);
        check({tag, ".data"}, rd_data(v.sel), v.edata);
        check({tag, ".err"},  error[v.sel], v.eerr);
        check({tag, ".perr"}, perr[v.sel],  v.eperr);
        check({tag, ".brk"},  brk[v.sel],   v.ebrk);
        check({tag, ".busy"}, busy[v.sel],  0);
    endtask

    initial begin
        int         n0, s;
        logic [7:0] w;
        vec_t       v;

        //          sel word     par   stop   edata    err   perr  brk   lat
        vt[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0, 1'b0, 155};
        vt[1]  = '{1, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0, 1'b0, 171};
        vt[2]  = '{1, 9'h03C, 1'b1, 2'b11, 9'h03C, 1'b0, 1'b1, 1'b0, 171};
        vt[3]  = '{2, 9'h055, 1'b1, 2'b11, 9'h055, 1'b0, 1'b0, 1'b0, 171};
        vt[4]  = '{2, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b1, 1'b0, 171};
        vt[5]  = '{0, 9'h081, 1'b0, 2'b00, 9'h081, 1'b1, 1'b0, 1'b0, 155};
        vt[6]  = '{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0, 1'b0, 171};
        vt[7]  = '{1, 9'h000, 1'b0, 2'b00, 9'h000, 1'b1, 1'b0, 1'b1, 171};
        vt[8]  = '{1, 9'h000, 1'b1, 2'b00, 9'h000, 1'b1, 1'b1, 1'b0, 171};
        vt[9]  = '{2, 9'h000, 1'b0, 2'b00, 9'h000, 1'b1, 1'b1, 1'b1, 171};
        vt[10] = '{2, 9'h02A, 1'b0, 2'b10, 9'h02A, 1'b1, 1'b0, 1'b0, 171};
        vt[11] = '{2, 9'h02A, 1'b0, 2'b01, 9'h02A, 1'b1, 1'b0, 1'b0, 171};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_idle_outputs(i, $sformatf("reset%0d", i));
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) apply(vt[i], $sformatf("vec%0d", i));

        // Glitch: 4 low cycles must be rejected at the half-bit check (t0 = s+3, HALF = 8).
        @(posedge clk); #1;
        n0 = nsgn[0];
        s  = cyc;
        drive(0, 1'b0, 3);
        check("glitch.busy_t0", busy[0], 1);
        drive(0, 1'b0, 1);
        line[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("glitch.busy_before_half", busy[0], 1);
        @(posedge clk); #1;
        check("glitch.busy_cleared_cycle", cyc - s, 11);
        check("glitch.busy_after_half", busy[0], 0);
        repeat (200) @(posedge clk);
        #1;
        check("glitch.no_sgn", nsgn[0] - n0, 0);

        // Break: line low for 20 bit times yields a single flagged frame.
        @(posedge clk); #1;
        n0 = nsgn[0];
        s  = cyc;
        drive(0, 1'b0, 20 * CPB);
        line[0] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("break.sgn_count", nsgn[0] - n0, 1);
        if (nsgn[0] > n0) check("break.latency", hcyc[0][n0 % 8] - s, 155);
        check("break.data", data_n, 0);
        check("break.err",  error[0], 1);
        check("break.brk",  brk[0], 1);
        check("break.perr", perr[0], 0);
        check("break.busy", busy[0], 0);
        v = '{0, 9'h042, 1'b0, 2'b11, 9'h042, 1'b0, 1'b0, 1'b0, 155};
        apply(v, "after_break");

        // Back-to-back frames, no idle: strobes spaced exactly one frame (160 cycles).
        @(posedge clk); #1;
        n0 = nsgn[0];
        s  = cyc;
        send_frame(0, 9'h001, 1'b0, 2'b11);
        send_frame(0, 9'h0FF, 1'b0, 2'b11);
        send_frame(0, 9'h080, 1'b0, 2'b11);
        repeat (20) @(posedge clk);
        #1;
        check("b2b.sgn_count", nsgn[0] - n0, 3);
        if (nsgn[0] - n0 >= 3) begin
            check("b2b.latency0", hcyc[0][n0 % 8] - s, 155);
            check("b2b.gap01", hcyc[0][(n0 + 1) % 8] - hcyc[0][n0 % 8], 160);
            check("b2b.gap12", hcyc[0][(n0 + 2) % 8] - hcyc[0][(n0 + 1) % 8], 160);
            check("b2b.data0", hdat[0][n0 % 8], 9'h001);
            check("b2b.data1", hdat[0][(n0 + 1) % 8], 9'h0FF);
            check("b2b.data2", hdat[0][(n0 + 2) % 8], 9'h080);
        end

        // Reset pulse during data bit 4 of 0x5A (bit 4 = 1, so the line stays high after).
        @(posedge clk); #1;
        n0 = nsgn[0];
        w  = 8'h5A;
        drive(0, 1'b0, CPB);
        for (int k = 0; k < 4; k++) drive(0, w[k], CPB);
        drive(0, w[4], 5);
        check("midrst.busy_before", busy[0], 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs(0, "midrst");
        check("midrst.data_e", data_e, 0);
        line[0] = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("midrst.no_sgn", nsgn[0] - n0, 0);
        v = '{0, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b0, 1'b0, 1'b0, 155};
        apply(v, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Parametrised asynchronous serial receiver. It is the successor of the fixed 8N1 `receive` block, with configurable oversampling, data width, parity and stop bits, plus explicit parity, framing and break reporting. It sits between the raw serial pin and the byte-level consumer. Each completed frame produces a single-cycle `sgn` pulse with `data` and status flags.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; legal range ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in`  in  1: asynchronous serial line; idles high.
- `sgn`  out  1: one-cycle frame-complete strobe.
- `data`  out  DATA_BITS: received word, LSB first on the line; valid when `sgn`=1.
- `error`  out  1: framing error; at least one stop bit sampled 0.
- `parity_err`  out  1: parity mismatch; always 0 when `PARITY`=0.
- `brk`  out  1: break; all data bits 0, parity bit 0 if present, stop bit(s) 0.
- `busy`  out  1: FSM not in IDLE.

## Operation
- **Synchroniser.** `in` passes through a 2-flop synchroniser, reset value 1. The FSM only ever sees the synchronised value `rx_s`.
- **Constants.** HALF = CLKS_PER_BIT/2 (integer division). The bit counter is clog2(CLKS_PER_BIT) wide.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE.** When `rx_s`=0: go to START and clear the cycle counter.
- **START.** At count HALF−1, sample `rx_s`.
  - If `rx_s`=0: go to DATA and clear the counter.
  - If `rx_s`=1: false start; return to IDLE. No flags change.
- **DATA.** Sample `rx_s` at count CLKS_PER_BIT−1 and shift it in LSB first. After DATA_BITS samples, go to PARITY if `PARITY`≠0, otherwise to STOP.
- **PARITY.** Sample one bit at count CLKS_PER_BIT−1.
  - Even: the XOR of data and parity must be 0.
  - Odd: the XOR must be 1.
- **STOP.** Sample STOP_BITS bits, each at count CLKS_PER_BIT−1. Any 0 sets framing-error internally.
- **End of frame.** On the cycle after the last stop sample, `sgn`=1 for exactly one cycle. On that same cycle `data`, `error`, `parity_err` and `brk` take the new frame's values. They hold until the next `sgn`.
- **After `sgn`.**
  - No framing error: go to IDLE; back-to-back frames are accepted.
  - Framing error: go to WAIT_HIGH, which returns to IDLE only once `rx_s`=1. A held-low break line therefore reports exactly one frame.
- **`brk` implies `error`.** The flags are independent otherwise.
- **Reset** at any time, including mid-frame, forces IDLE and discards the partial frame. No `sgn` is produced for a discarded frame.
- **Reset values:**
  - `sgn`=0, `data`=0, `error`=0, `parity_err`=0, `brk`=0, `busy`=0.
  - Synchroniser flops = 1; shift register and counters = 0.

## Timing
- Let t0 be the first edge on which IDLE sees `rx_s`=0. The pin edge precedes t0 by 2–3 cycles (synchroniser).
- Start check: cycle t0+HALF.
- Data bit k (k=0..DATA_BITS−1): sampled at t0+HALF+(k+1)·CLKS_PER_BIT.
- Parity bit: sampled at t0+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
- Stop bit j: sampled at t0+HALF+(DATA_BITS+P+1+j)·CLKS_PER_BIT, where P = (PARITY≠0).
- `sgn`: asserted one cycle after the last stop sample. For 8N1 with CLKS_PER_BIT=16 this is t0+153.
- `busy`: 1 from t0+1 until the cycle IDLE is re-entered.
- A start edge arriving in the `sgn` cycle is detected on the following cycle.
- No input handshake; `sgn` is not back-pressured. The consumer must capture `data` before the next `sgn`.

## Structure
- **Package `uart_pkg`:**
  - Parity-mode constants: PAR_NONE, PAR_EVEN, PAR_ODD.
  - FSM state typedef/encoding.
  - clog2-based counter-width function.
  - These are shared with the future transmitter.
- **Sub-module `uart_sync`:** 2-flop synchroniser with a reset-value parameter, instantiated once.
- The FSM, counters, shift register and flag logic live in `uart_rx`.

## Test plan
All scenarios use clk period 2 and a 32-unit bit time, i.e. CLKS_PER_BIT=16, matching the existing bench timing.
1. **8N1 nominal.** Send 0xA5 → exactly one `sgn` at t0+153; `data`=0xA5; `error`=`parity_err`=`brk`=0.
2. **8E1 parity.** Send 0x3C with parity bit 0 → `parity_err`=0. Send 0x3C with parity bit 1 → `parity_err`=1 and `data`=0x3C. Repeat with 7O2 and 0x55.
3. **Glitch rejection.** Pulse the line low for 4 cycles, then hold high → no `sgn`; `busy` returns to 0 by t0+HALF+1.
4. **Framing error and break.**
   - Send 0x81 with the stop bit held 0 → `sgn`, `error`=1, `brk`=0.
   - Hold the line low for 20 bit times → one `sgn` with `data`=0x00, `error`=`brk`=1, and no further `sgn`.
   - After the line returns high, send 0x42 → `data`=0x42 with all flags 0.
5. **Back-to-back frames.** Send 0x01, 0xFF, 0x80 with no idle between them → three `sgn` pulses exactly 160 cycles apart, with correct data for each.
6. **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 4 → all outputs return to their reset values and no `sgn` is produced. The next frame, 0x5A, is received correctly.
